// File: rtl/trig_sched_pkg.sv
// Shared types and constants for the attitude trig scheduler: FSM states,
// angle index encoding and fixed-point constants.
package trig_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam int ANGLE_MOD = 360;
  localparam int ONE_Q16   = 1 << 16;

  typedef logic [1:0] angle_idx_t;

  localparam angle_idx_t IDX_PITCH = 2'd0;
  localparam angle_idx_t IDX_ROLL  = 2'd1;
  localparam angle_idx_t IDX_YAW   = 2'd2;

  // States in which a pass is in flight and new requests must be parked.
  function automatic logic is_busy_state(input state_t s);
    return (s == ISSUE) || (s == WAIT) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/trig_scheduler_wrap.sv
// Single-step modulo-360 reduction for integrator angles; inputs never exceed
// 511, so one conditional subtraction is enough.
module angle_wrap_360
  import trig_sched_pkg::*;
#(
  parameter int ANGLE_W = 9
) (
  input  logic [ANGLE_W-1:0] angle_raw,
  output logic [ANGLE_W-1:0] angle_wrapped
);

  localparam logic [ANGLE_W-1:0] MOD = ANGLE_W'(ANGLE_MOD);

  logic [ANGLE_W-1:0] diff;

  assign diff          = angle_raw - MOD;
  assign angle_wrapped = (angle_raw >= MOD) ? diff : angle_raw;

endmodule

// File: rtl/trig_scheduler.sv
// Shares one sin/cos unit across pitch, roll and yaw: issues each angle in
// turn, waits out the unit latency and captures the six results.
module trig_scheduler
  import trig_sched_pkg::*;
#(
  parameter int TRIG_LATENCY = 2,
  parameter int ANGLE_W      = 9,
  parameter int AMP_W        = 32
) (
  input  logic               clk_100mhz,
  input  logic               rst_in,
  input  logic               angle_valid,
  input  logic [ANGLE_W-1:0] pitch,
  input  logic [ANGLE_W-1:0] roll,
  input  logic [ANGLE_W-1:0] yaw,
  output logic               trig_start,
  output logic [ANGLE_W-1:0] trig_value,
  input  logic [AMP_W-1:0]   trig_sin_in,
  input  logic [AMP_W-1:0]   trig_cos_in,
  output logic [AMP_W-1:0]   pitch_sin,
  output logic [AMP_W-1:0]   pitch_cos,
  output logic [AMP_W-1:0]   roll_sin,
  output logic [AMP_W-1:0]   roll_cos,
  output logic [AMP_W-1:0]   yaw_sin,
  output logic [AMP_W-1:0]   yaw_cos,
  output logic               results_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int WAIT_LAST = (TRIG_LATENCY > 1) ? TRIG_LATENCY - 2 : 0;
  localparam int CNT_W     = (TRIG_LATENCY > 2) ? $clog2(TRIG_LATENCY) : 1;

  state_t                     state_q, state_d;
  angle_idx_t                 idx_q;
  logic [CNT_W-1:0]           wait_cnt_q;
  logic [2:0][ANGLE_W-1:0]    in_wrapped;
  logic [2:0][ANGLE_W-1:0]    work_q;
  logic [2:0][ANGLE_W-1:0]    pend_q;
  logic                       pend_full_q;
  logic [ANGLE_W-1:0]         last_value_q;
  logic [2:0][AMP_W-1:0]      sin_q;
  logic [2:0][AMP_W-1:0]      cos_q;
  logic                       accept_slot;

  angle_wrap_360 #(.ANGLE_W(ANGLE_W)) u_wrap_pitch (
    .angle_raw     (pitch),
    .angle_wrapped (in_wrapped[IDX_PITCH])
  );

  angle_wrap_360 #(.ANGLE_W(ANGLE_W)) u_wrap_roll (
    .angle_raw     (roll),
    .angle_wrapped (in_wrapped[IDX_ROLL])
  );

  angle_wrap_360 #(.ANGLE_W(ANGLE_W)) u_wrap_yaw (
    .angle_raw     (yaw),
    .angle_wrapped (in_wrapped[IDX_YAW])
  );

  // IDLE and DONE are the only points where a new working set may be loaded.
  assign accept_slot = (state_q == IDLE) || (state_q == DONE);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (angle_valid || pend_full_q) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = (TRIG_LATENCY > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wait_cnt_q == CNT_W'(WAIT_LAST)) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = (idx_q == IDX_YAW) ? DONE : ISSUE;
      end
      DONE: begin
        state_d = (angle_valid || pend_full_q) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trig_start    = (state_q == ISSUE);
    trig_value    = (state_q == ISSUE) ? work_q[idx_q] : last_value_q;
    results_valid = (state_q == DONE);
    busy          = is_busy_state(state_q);
    overrun       = angle_valid && pend_full_q;
  end

  // NOTE: angle holding registers carry no reset; state_q and pend_full_q decide whether they mean anything.
  always_ff @(posedge clk_100mhz) begin
    if (accept_slot) begin
      if (angle_valid) begin
        work_q <= in_wrapped;
      end else if (pend_full_q) begin
        work_q <= pend_q;
      end
    end else if (angle_valid) begin
      pend_q <= in_wrapped;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      idx_q        <= IDX_PITCH;
      wait_cnt_q   <= '0;
      pend_full_q  <= 1'b0;
      last_value_q <= '0;
      sin_q        <= '0;
      cos_q        <= '0;
    end else begin
      // A request seen at IDLE/DONE goes straight to the working set.
      if (accept_slot) begin
        if (angle_valid || pend_full_q) pend_full_q <= 1'b0;
      end else if (angle_valid) begin
        pend_full_q <= 1'b1;
      end

      case (state_q)
        ISSUE: begin
          wait_cnt_q   <= '0;
          last_value_q <= work_q[idx_q];
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        CAPTURE: begin
          sin_q[idx_q] <= trig_sin_in;
          cos_q[idx_q] <= trig_cos_in;
          idx_q        <= (idx_q == IDX_YAW) ? IDX_PITCH : idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign pitch_sin = sin_q[IDX_PITCH];
  assign pitch_cos = cos_q[IDX_PITCH];
  assign roll_sin  = sin_q[IDX_ROLL];
  assign roll_cos  = cos_q[IDX_ROLL];
  assign yaw_sin   = sin_q[IDX_YAW];
  assign yaw_cos   = cos_q[IDX_YAW];

endmodule

// File: doc/trig_scheduler.md
Name: trig_scheduler

Overview:
- Time-multiplexes one shared sine/cosine evaluation unit across the three integrated attitude angles (pitch, roll, yaw).
- Sits between the gyro integrator, which outputs 9-bit degree angles, and the view-vector stage, which consumes sin/cos of each angle.
- One set of three angles is processed per request; one trig unit is instantiated instead of six.

Parameters:
- TRIG_LATENCY, 2, cycles from trig_start/trig_value to valid trig_sin_in/trig_cos_in (must be >= 1).
- ANGLE_W, 9, angle width in whole degrees.
- AMP_W, 32, signed trig amplitude width (16 fractional bits, 1.0 = 1<<16).

Ports:
- clk_100mhz  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- angle_valid  in  1  single-cycle pulse; pitch/roll/yaw are valid this cycle.
- pitch  in  ANGLE_W  pitch angle in degrees.
- roll  in  ANGLE_W  roll angle in degrees.
- yaw  in  ANGLE_W  yaw angle in degrees.
- trig_start  out  1  one-cycle issue strobe to the shared trig unit.
- trig_value  out  ANGLE_W  angle issued to the trig unit, always 0..359.
- trig_sin_in  in  AMP_W  signed sine result from the trig unit.
- trig_cos_in  in  AMP_W  signed cosine result from the trig unit.
- pitch_sin, pitch_cos, roll_sin, roll_cos, yaw_sin, yaw_cos  out  AMP_W each  registered results.
- results_valid  out  1  one-cycle pulse when all six results have updated.
- busy  out  1  high from the cycle after acceptance until results_valid.
- overrun  out  1  one-cycle pulse when a pending request is overwritten.

Behaviour:
- Reset: all six results 0, results_valid 0, busy 0, overrun 0, trig_start 0, trig_value 0, FSM IDLE, pending empty, index 0.
- Angle wrap on capture: if an angle is >= 360, subtract 360. For example 400 -> 40 and 359 -> 359. Values 360..511 wrap once; 511 -> 151.
- FSM states and transitions:
  - IDLE -> ISSUE on angle_valid, or when pending is full.
  - ISSUE: one cycle. Drives trig_start=1 and trig_value=angle[index]. Then -> WAIT.
  - WAIT: counts TRIG_LATENCY-1 cycles, then -> CAPTURE.
  - CAPTURE: samples trig_sin_in/trig_cos_in into the result registers for the current index.
    - If index < 2: index++ and -> ISSUE.
    - Else: -> DONE.
  - DONE: results_valid=1 for one cycle, busy drops. Then -> ISSUE if pending is full (pending moves to the working set), else IDLE.
- Timing, with angle_valid at cycle t and L = TRIG_LATENCY:
  - Pitch issue at t+1, pitch capture at t+1+L.
  - Roll issue at t+L+2.
  - Yaw issue at t+2L+3, yaw capture at t+3L+3.
  - results_valid at t+3L+4 (t+10 for L=2).
  - Issues are spaced exactly L+1 cycles apart.
- trig_value holds its last issued value between issues. trig_start is never high in two consecutive cycles.
- Results update only in CAPTURE for their own angle, so within one pass pitch outputs are new while yaw outputs still hold the old value. Consumers sample only on results_valid.
- angle_valid while busy: the angles are wrapped and latched into a one-deep pending register.
  - If pending is already full, it is overwritten (latest wins) and overrun pulses that cycle.
- angle_valid in the same cycle as DONE: goes to pending, and is serviced starting the next cycle.
- angle_valid in IDLE with pending empty: accepted directly; no overrun.
- The working set is frozen from acceptance to DONE; input changes never corrupt an in-flight pass.
- Reset mid-pass: returns to the reset state next edge. The trig unit may still return a result, which is ignored.

Decomposition:
- Package trig_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, CAPTURE, DONE};
  - ANGLE_MOD = 360;
  - 2-bit index typedef (0=pitch, 1=roll, 2=yaw);
  - ONE_Q16 = 1<<16.
- Sub-module angle_wrap_360: combinational, ANGLE_W in/out, one subtraction and compare. Instantiated three times on the capture path.

Test Plan:
- Reset, then angle_valid with pitch=0, roll=90, yaw=180 and a stub trig model (L=2) -> trig_start at t+1, t+4, t+7 with values 0, 90, 180.
  - results_valid only at t+10.
  - pitch_cos=65536, roll_sin=65536, yaw_cos=-65536.
- Angle wrap: pitch=400, roll=360, yaw=511 -> trig_value sequence 40, 0, 151.
- Pending and overrun: requests A at t, B at t+3, C at t+5.
  - overrun pulses at t+5 only.
  - The second pass uses C's angles and starts the cycle after the first results_valid; B is never issued.
- Request at DONE: angle_valid coincides with results_valid -> no overrun; next trig_start exactly one cycle later.
- Reset mid-pass: rst_in asserted at the roll WAIT.
  - Next cycle: all outputs 0 and busy 0.
  - A new request then completes normally at t'+10.
- Parameter sweep with TRIG_LATENCY=1 and 5 -> results_valid at t+7 and t+19; issue spacing 2 and 6 cycles.
